// File: rtl/int_request_ctrl_if.sv
// int_request_ctrl_if: request/response bundle between hand-off requesters and int_request_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; the controller drops requests it cannot take and flags req_dropped.
// Ports: master = requester side (drives *_req/*_pc_in, observes results);
//        slave  = controller side (observes requests, drives pulses, PCs and status).
interface int_request_ctrl_if #(
  parameter int PC_W = 32
);
  logic            cpu_fp_req;
  logic [PC_W-1:0] cpu_pc_in;
  logic            fpu_done_req;
  logic [PC_W-1:0] fpu_pc_in;
  logic            cpu_int;
  logic            fpu_int;
  logic [PC_W-1:0] cpu_pc;
  logic [PC_W-1:0] fpu_pc;
  logic            owner;
  logic            busy;
  logic            req_dropped;
  logic            timeout_err;
  logic [15:0]     switch_count;

  modport master (
    output cpu_fp_req, cpu_pc_in, fpu_done_req, fpu_pc_in,
    input  cpu_int, fpu_int, cpu_pc, fpu_pc, owner, busy,
           req_dropped, timeout_err, switch_count
  );

  modport slave (
    input  cpu_fp_req, cpu_pc_in, fpu_done_req, fpu_pc_in,
    output cpu_int, fpu_int, cpu_pc, fpu_pc, owner, busy,
           req_dropped, timeout_err, switch_count
  );
endinterface

// File: rtl/int_request_ctrl.sv
// int_request_ctrl: turns raw CPU<->FPU hand-off requests into exclusive, fixed-width interrupt pulses.
// Latency: PC captured on the accepting edge; pulse rises one cycle later and lasts PULSE_W cycles.
// Backpressure: none; requests arriving while busy or for the non-owning side are dropped (req_dropped).
// Ports: clk, reset_n (async, active low); bus (slave modport) carries requests in and
//        cpu_int/fpu_int, captured PCs, owner, busy, req_dropped, timeout_err, switch_count out.
module int_request_ctrl #(
  parameter int PC_W    = 32,
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               reset_n,
  int_request_ctrl_if.slave bus
);

  localparam int PCNT_W = $clog2(PULSE_W + 1);
  localparam int WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_W);
  // Only meaningful when TIMEOUT != 0; the watchdog branch is disabled otherwise.
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    CPU_RUN = 2'd0,
    TO_FPU  = 2'd1,
    FPU_RUN = 2'd2,
    TO_CPU  = 2'd3
  } state_t;

  state_t            state;
  logic [PCNT_W-1:0] pulse_cnt;
  logic [WD_W-1:0]   wd_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= CPU_RUN;
      pulse_cnt        <= '0;
      wd_cnt           <= '0;
      bus.cpu_int      <= 1'b0;
      bus.fpu_int      <= 1'b0;
      bus.cpu_pc       <= '0;
      bus.fpu_pc       <= '0;
      bus.owner        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.req_dropped  <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.switch_count <= '0;
    end else begin
      bus.req_dropped <= 1'b0;
      case (state)
        CPU_RUN: begin
          // A done request is meaningless while the CPU owns execution.
          bus.req_dropped <= bus.fpu_done_req;
          if (bus.cpu_fp_req) begin
            bus.cpu_pc       <= bus.cpu_pc_in;
            bus.switch_count <= bus.switch_count + 16'd1;
            bus.busy         <= 1'b1;
            pulse_cnt        <= '0;
            state            <= TO_FPU;
          end
        end

        TO_FPU: begin
          bus.req_dropped <= bus.cpu_fp_req | bus.fpu_done_req;
          // First cycle in this state keeps cpu_int low so cpu_pc settles before the rising edge.
          if (pulse_cnt == PULSE_LAST) begin
            bus.cpu_int <= 1'b0;
            bus.owner   <= 1'b1;
            bus.busy    <= 1'b0;
            wd_cnt      <= '0;
            state       <= FPU_RUN;
          end else begin
            bus.cpu_int <= 1'b1;
            pulse_cnt   <= pulse_cnt + PCNT_W'(1);
          end
        end

        FPU_RUN: begin
          bus.req_dropped <= bus.cpu_fp_req;
          if (bus.fpu_done_req) begin
            bus.fpu_pc       <= bus.fpu_pc_in;
            bus.switch_count <= bus.switch_count + 16'd1;
            bus.busy         <= 1'b1;
            pulse_cnt        <= '0;
            state            <= TO_CPU;
          end else if (TIMEOUT != 0 && wd_cnt == WD_LAST) begin
            // Forced return skips the offloaded instruction.
            bus.fpu_pc       <= bus.cpu_pc + PC_W'(4);
            bus.timeout_err  <= 1'b1;
            bus.switch_count <= bus.switch_count + 16'd1;
            bus.busy         <= 1'b1;
            pulse_cnt        <= '0;
            state            <= TO_CPU;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        TO_CPU: begin
          bus.req_dropped <= bus.cpu_fp_req | bus.fpu_done_req;
          if (pulse_cnt == PULSE_LAST) begin
            bus.fpu_int <= 1'b0;
            bus.owner   <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= CPU_RUN;
          end else begin
            bus.fpu_int <= 1'b1;
            pulse_cnt   <= pulse_cnt + PCNT_W'(1);
          end
        end

        default: state <= CPU_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_int_request_ctrl.sv
// tb_int_request_ctrl: randomized + directed bench for int_request_ctrl against a timestamp-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_int_request_ctrl;

  localparam int PW = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_request_ctrl_if #(.PC_W(32)) ifa ();
  int_request_ctrl_if #(.PC_W(32)) ifb ();

  int_request_ctrl #(.PC_W(32), .PULSE_W(PW), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset_n(rst_n), .bus(ifa)
  );

  int_request_ctrl #(.PC_W(32), .PULSE_W(PW), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset_n(rst_n), .bus(ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: remembers the edge index of the last accepted hand-off and its direction;
  // every output is derived from the distance to that edge.
  longint      m_cur = 0;
  longint      m_acc = 0;
  bit          m_any = 0;
  bit          m_dir_fpu = 0;
  logic [31:0] m_cpu_pc = '0;
  logic [31:0] m_fpu_pc = '0;
  logic [15:0] m_cnt = '0;
  bit          m_terr = 0;
  bit          m_drop = 0;

  task automatic model_reset();
    m_cur = 0; m_acc = 0; m_any = 0; m_dir_fpu = 0;
    m_cpu_pc = '0; m_fpu_pc = '0; m_cnt = '0; m_terr = 0; m_drop = 0;
  endtask

  task automatic accept(input longint e, input bit to_fpu);
    m_acc = e; m_any = 1; m_dir_fpu = to_fpu; m_cnt = m_cnt + 16'd1;
  endtask

  task automatic model_step();
    longint e;
    bit in_flight;
    bit fpu_owns;
    e = m_cur + 1;
    in_flight = m_any && (m_cur - m_acc) <= PW;
    fpu_owns = m_any && m_dir_fpu;
    m_drop = 0;
    if (in_flight) begin
      m_drop = ifa.cpu_fp_req | ifa.fpu_done_req;
    end else if (!fpu_owns) begin
      m_drop = ifa.fpu_done_req;
      if (ifa.cpu_fp_req) begin
        m_cpu_pc = ifa.cpu_pc_in;
        accept(e, 1);
      end
    end else begin
      m_drop = ifa.cpu_fp_req;
      if (ifa.fpu_done_req) begin
        m_fpu_pc = ifa.fpu_pc_in;
        accept(e, 0);
      end else if (e - (m_acc + PW + 1) == TO) begin
        m_fpu_pc = m_cpu_pc + 32'd4;
        m_terr = 1;
        accept(e, 0);
      end
    end
    m_cur = e;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic compare_all();
    longint d;
    bit win;
    d = m_cur - m_acc;
    win = m_any && d <= PW;
    check("cpu_int",      ifa.cpu_int,      win && m_dir_fpu && d >= 1);
    check("fpu_int",      ifa.fpu_int,      win && !m_dir_fpu && d >= 1);
    check("busy",         ifa.busy,         win);
    check("owner",        ifa.owner,        m_any && (m_dir_fpu ^ win));
    check("cpu_pc",       ifa.cpu_pc,       m_cpu_pc);
    check("fpu_pc",       ifa.fpu_pc,       m_fpu_pc);
    check("req_dropped",  ifa.req_dropped,  m_drop);
    check("timeout_err",  ifa.timeout_err,  m_terr);
    check("switch_count", ifa.switch_count, m_cnt);
  endtask

  always @(negedge clk) begin
    if (rst_n) compare_all();
  end

  task automatic cpu_req(input logic [31:0] pc);
    ifa.cpu_fp_req = 1'b1; ifa.cpu_pc_in = pc;
    @(negedge clk);
    ifa.cpu_fp_req = 1'b0;
  endtask

  task automatic fpu_req(input logic [31:0] pc);
    ifa.fpu_done_req = 1'b1; ifa.fpu_pc_in = pc;
    @(negedge clk);
    ifa.fpu_done_req = 1'b0;
  endtask

  task automatic wait_owner(input bit exp, input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifa.owner == exp) break;
    end
    check(tag, ifa.owner, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int k;
    int hi;
    bit seen;
    ifa.cpu_fp_req = 0; ifa.fpu_done_req = 0; ifa.cpu_pc_in = '0; ifa.fpu_pc_in = '0;
    ifb.cpu_fp_req = 0; ifb.fpu_done_req = 0; ifb.cpu_pc_in = '0; ifb.fpu_pc_in = '0;
    @(negedge clk);
    do_reset();
    check("rst_owner", ifa.owner, 0);
    check("rst_cnt", ifa.switch_count, 0);
    check("rst_pc", ifa.cpu_pc | ifa.fpu_pc, 0);

    // Basic round trip.
    cpu_req(32'h100);
    check("rt_cpu_pc", ifa.cpu_pc, 32'h100);
    check("rt_cpu_int_pre", ifa.cpu_int, 0);
    @(negedge clk); check("rt_cpu_int_1", ifa.cpu_int, 1);
    @(negedge clk); check("rt_cpu_int_2", ifa.cpu_int, 1);
    @(negedge clk); check("rt_cpu_int_end", ifa.cpu_int, 0);
    check("rt_owner_fpu", ifa.owner, 1);
    fpu_req(32'h104);
    check("rt_fpu_pc", ifa.fpu_pc, 32'h104);
    @(negedge clk); check("rt_fpu_int_1", ifa.fpu_int, 1);
    @(negedge clk); check("rt_fpu_int_2", ifa.fpu_int, 1);
    @(negedge clk); check("rt_fpu_int_end", ifa.fpu_int, 0);
    check("rt_owner_cpu", ifa.owner, 0);
    check("rt_count", ifa.switch_count, 2);

    // Simultaneous requests in CPU_RUN, then in FPU_RUN.
    ifa.cpu_fp_req = 1; ifa.cpu_pc_in = 32'h300; ifa.fpu_done_req = 1; ifa.fpu_pc_in = 32'h3FF;
    @(negedge clk);
    ifa.cpu_fp_req = 0; ifa.fpu_done_req = 0;
    check("sim_c_drop", ifa.req_dropped, 1);
    check("sim_c_fpu_pc", ifa.fpu_pc, 32'h104);
    @(negedge clk);
    check("sim_c_drop_once", ifa.req_dropped, 0);
    check("sim_c_cpu_int", ifa.cpu_int, 1);
    wait_owner(1, "sim_c_owner");
    ifa.cpu_fp_req = 1; ifa.cpu_pc_in = 32'h310; ifa.fpu_done_req = 1; ifa.fpu_pc_in = 32'h304;
    @(negedge clk);
    ifa.cpu_fp_req = 0; ifa.fpu_done_req = 0;
    check("sim_f_drop", ifa.req_dropped, 1);
    check("sim_f_fpu_pc", ifa.fpu_pc, 32'h304);
    check("sim_f_cpu_pc", ifa.cpu_pc, 32'h300);
    @(negedge clk);
    check("sim_f_fpu_int", ifa.fpu_int, 1);
    check("sim_f_cpu_int", ifa.cpu_int, 0);
    wait_owner(0, "sim_f_owner");

    // Busy drop: second request inside the pulse is dropped, pulse width unchanged.
    cpu_req(32'h400);
    cpu_req(32'h999);
    check("bd_drop", ifa.req_dropped, 1);
    check("bd_cpu_pc", ifa.cpu_pc, 32'h400);
    hi = ifa.cpu_int ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifa.cpu_int) hi++; else break;
    end
    check("bd_width", hi, PW);
    fpu_req(32'h404);
    wait_owner(0, "bd_owner");

    // Watchdog expiry.
    cpu_req(32'h200);
    wait_owner(1, "wd_owner");
    k = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      k++;
      if (ifa.fpu_int) break;
    end
    check("wd_latency", k, TO + 1);
    check("wd_fpu_pc", ifa.fpu_pc, 32'h204);
    check("wd_err", ifa.timeout_err, 1);
    wait_owner(0, "wd_back");
    cpu_req(32'h240);
    wait_owner(1, "wd_rt_owner");
    fpu_req(32'h244);
    wait_owner(0, "wd_rt_back");
    check("wd_err_sticky", ifa.timeout_err, 1);

    // Done request on the expiry edge wins.
    do_reset();
    cpu_req(32'h200);
    wait_owner(1, "wdd_owner");
    repeat (TO - 1) @(negedge clk);
    fpu_req(32'h5A0);
    check("wdd_fpu_pc", ifa.fpu_pc, 32'h5A0);
    check("wdd_err", ifa.timeout_err, 0);
    wait_owner(0, "wdd_back");

    // Counter wrap and PC wrap on forced return.
    @(posedge clk); #2;
    force ifa.switch_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(posedge clk); #2;
    release ifa.switch_count;
    @(negedge clk);
    check("wrap_pre", ifa.switch_count, 16'hFFFF);
    cpu_req(32'hFFFF_FFFC);
    check("wrap_cnt", ifa.switch_count, 0);
    wait_owner(1, "wrap_owner");
    wait_owner(0, "wrap_back");
    check("wrap_fpu_pc", ifa.fpu_pc, 32'h0);
    check("wrap_cnt2", ifa.switch_count, 1);

    // Reset in the middle of a pulse.
    cpu_req(32'h700);
    @(negedge clk);
    check("mr_int_pre", ifa.cpu_int, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_int", ifa.cpu_int, 0);
    check("mr_busy", ifa.busy, 0);
    check("mr_pc", ifa.cpu_pc, 0);
    check("mr_cnt", ifa.switch_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_owner", ifa.owner, 0);
    check("mr_err", ifa.timeout_err, 0);

    // Watchdog disabled instance stays with the FPU.
    ifb.cpu_fp_req = 1; ifb.cpu_pc_in = 32'h800;
    @(negedge clk);
    ifb.cpu_fp_req = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifb.owner) break;
      @(negedge clk);
    end
    check("nowd_owner", ifb.owner, 1);
    seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ifb.fpu_int || !ifb.owner) seen = 1;
    end
    check("nowd_no_return", seen, 0);
    check("nowd_err", ifb.timeout_err, 0);
    check("nowd_cnt", ifb.switch_count, 1);

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      ifa.cpu_fp_req   = ($urandom_range(0, 99) < 30);
      ifa.fpu_done_req = ($urandom_range(0, 99) < 12);
      ifa.cpu_pc_in    = $urandom;
      ifa.fpu_pc_in    = $urandom;
      @(negedge clk);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        check("rnd_rst_ints", ifa.cpu_int | ifa.fpu_int, 0);
        check("rnd_rst_busy", ifa.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    ifa.cpu_fp_req = 0; ifa.fpu_done_req = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_request_ctrl.md
Name: int_request_ctrl

Overview:
- Sits directly upstream of the CPU/FPU interrupt handler and produces its cpu_int, fpu_int, cpu_pc and fpu_pc inputs.
- Converts raw, possibly overlapping hand-off requests into clean, mutually exclusive, fixed-width interrupt pulses, with registered PCs that are stable before each pulse.
- Tracks which unit currently owns execution and counts hand-offs.
- Runs a watchdog that forces control back to the CPU if the FPU never returns.

Parameters:
- PC_W, 32: width of all PC inputs and outputs.
- PULSE_W, 2: cycles each interrupt pulse stays high. Legal range is ≥1.
- TIMEOUT, 1024: maximum number of FPU_RUN cycles before a forced return. 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_fp_req  in  1  CPU has decoded an FP instruction and requests hand-off to the FPU. Sampled every cycle.
- cpu_pc_in  in  PC_W  PC of the requesting CPU instruction. Valid with cpu_fp_req.
- fpu_done_req  in  1  FPU has finished and requests return to the CPU. Sampled every cycle.
- fpu_pc_in  in  PC_W  return PC from the FPU. Valid with fpu_done_req.
- cpu_int  out  1  pulse that moves control to the FPU. Feeds the handler's cpu_int.
- fpu_int  out  1  pulse that moves control to the CPU. Feeds the handler's fpu_int.
- cpu_pc  out  PC_W  captured CPU PC. Feeds the handler.
- fpu_pc  out  PC_W  captured FPU return PC. Feeds the handler.
- owner  out  1  0 = CPU owns execution, 1 = FPU owns execution.
- busy  out  1  high while a pulse is in progress (TO_FPU or TO_CPU state).
- req_dropped  out  1  one-cycle pulse when a request is ignored.
- timeout_err  out  1  sticky flag: the watchdog fired. Cleared only by reset.
- switch_count  out  16  number of hand-offs. Wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async, reset_n=0):
  - state = CPU_RUN.
  - All outputs 0, including both PCs, the counters and timeout_err.
  - Reset mid-pulse drops the pulse immediately.
- All outputs are registered. No combinational path from any input to any output.
- States: CPU_RUN, TO_FPU, FPU_RUN, TO_CPU.
- CPU_RUN:
  - cpu_fp_req=1 at edge t: cpu_pc <= cpu_pc_in, switch_count +1, next state TO_FPU.
  - fpu_done_req here is ignored and pulses req_dropped. This also applies when it arrives in the same cycle as cpu_fp_req; the CPU request wins.
- TO_FPU:
  - cpu_int=1 for exactly PULSE_W cycles, starting the cycle after t.
  - cpu_pc holds its captured value for the whole pulse and afterwards.
  - After the last pulse cycle: next state FPU_RUN, owner <= 1, cpu_int <= 0.
- FPU_RUN:
  - The watchdog counter is cleared on entry and increments each cycle.
  - fpu_done_req=1: fpu_pc <= fpu_pc_in, switch_count +1, next state TO_CPU.
  - cpu_fp_req here is ignored and pulses req_dropped. This also applies when both requests arrive together; the FPU request wins.
  - Watchdog: if TIMEOUT≠0, the counter reaches TIMEOUT-1 and fpu_done_req=0, then:
    - fpu_pc <= cpu_pc + 4 (the FP instruction is skipped; addition modulo 2^PC_W);
    - timeout_err <= 1, switch_count +1, next state TO_CPU.
  - The forced return therefore starts after exactly TIMEOUT FPU_RUN cycles.
  - fpu_done_req on the same edge as the watchdog expiry takes priority: fpu_pc_in is used and timeout_err is not set.
- TO_CPU:
  - Mirror of TO_FPU: fpu_int high for PULSE_W cycles.
  - Then next state CPU_RUN, owner <= 0.
- During TO_FPU or TO_CPU: every request is ignored and pulses req_dropped. Nothing is queued.
- Invariants:
  - cpu_int and fpu_int are never high together.
  - Between any two pulses there is at least one low cycle, so the handler sees a clean rising edge.
  - Each captured PC is stable for at least one cycle before its pulse rises.
- busy = (state == TO_FPU or state == TO_CPU), registered together with the state.
- req_dropped pulses at most once per cycle, even if both requests are dropped in that cycle.

Test Plan:
- Reset: assert reset_n=0 mid-TO_FPU -> cpu_int drops immediately; every output reads 0 and owner=0 after release.
- Basic round trip: with PULSE_W=2, cpu_fp_req with cpu_pc_in=0x100 -> cpu_pc=0x100 and cpu_int high for 2 cycles, then owner=1. Then fpu_done_req with fpu_pc_in=0x104 -> fpu_int high for 2 cycles, fpu_pc=0x104, owner=0, switch_count=2.
- Simultaneous requests:
  - both asserted in CPU_RUN -> only cpu_int fires, req_dropped=1 for 1 cycle;
  - both asserted in FPU_RUN -> only fpu_int fires, req_dropped=1 for 1 cycle.
- Watchdog: with TIMEOUT=8, cpu_pc=0x200 and no done request -> fpu_int rises after 8 FPU_RUN cycles, fpu_pc=0x204, timeout_err=1 and it stays 1 through later round trips. Repeat with fpu_done_req on the expiry edge -> fpu_pc=fpu_pc_in and timeout_err stays 0.
- Busy drop: pulse cpu_fp_req again during TO_FPU -> req_dropped pulses, cpu_pc is unchanged, and the pulse still lasts exactly PULSE_W cycles.
- Wrap and disable:
  - preload 65535 round-trip halves -> the next hand-off makes switch_count 0x0000;
  - cpu_pc=0xFFFFFFFC with a watchdog expiry -> fpu_pc=0x00000000;
  - TIMEOUT=0 -> no forced return after 5000 cycles.
